// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_multi
//  Purpose  : SPI master with multiple slave selects, programmable length
//             (1..SPI_MAXLEN), MSB/LSB-first order, internal loopback and an
//             inter-transfer idle gap. MOSI changes on posedge SCLK, receive
//             data is sampled on negedge SCLK.
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_multi #(
   parameter int SPI_MAXLEN = 16,
   parameter int NUM_SS     = 4,
   parameter int GAP_CLKS   = 2
) (
   input  logic                          SCLK,
   input  logic                          sresetn,
   input  logic                          start_cmd,
   output logic                          spi_drv_rdy,
   input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
   input  logic [SPI_MAXLEN-1:0]         tx_data,
   input  logic [$clog2(NUM_SS)-1:0]     ss_sel,
   input  logic                          lsb_first,
   input  logic                          loop_en,
   output logic [SPI_MAXLEN-1:0]         rx_data,
   output logic                          rx_valid,
   output logic                          cmd_err,
   output logic                          MOSI,
   input  logic                          MISO,
   output logic [NUM_SS-1:0]             SS_N
);

   // Counter wide enough to hold SPI_MAXLEN itself (no overflow on full length)
   localparam int                c_CW       = $clog2(SPI_MAXLEN) + 1;
   localparam int                c_SSW      = $clog2(NUM_SS);
   localparam logic [c_CW-1:0]   c_MAXLEN   = c_CW'(SPI_MAXLEN);
   localparam logic [c_CW-1:0]   c_ONE      = c_CW'(1);
   localparam logic [3:0]        c_GAP_LOAD = (GAP_CLKS > 0) ? 4'(GAP_CLKS - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t                 state_q,    state_d;
   logic                   rdy_q,      rdy_d;
   logic [c_CW-1:0]        cnt_q,      cnt_d;
   logic [c_CW-1:0]        n_q,        n_d;
   logic                   lsb_q,      lsb_d;
   logic                   loop_q,     loop_d;
   logic [SPI_MAXLEN-1:0]  tx_sh_q,    tx_sh_d;
   logic                   mosi_q,     mosi_d;
   logic [NUM_SS-1:0]      ss_n_q,     ss_n_d;
   logic [SPI_MAXLEN-1:0]  rx_data_q,  rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   cmd_err_q,  cmd_err_d;
   logic [3:0]             gap_q,      gap_d;
   logic [SPI_MAXLEN-1:0]  rx_sh_q,    rx_sh_d;

   logic                   w_ss_bad;
   logic                   w_len_bad;
   logic                   w_cmd_bad;
   logic [c_CW-1:0]        w_shamt;
   logic [SPI_MAXLEN-1:0]  w_tx_aligned;
   logic [NUM_SS-1:0]      w_ss_n_sel;
   logic                   w_rx_bit;
   logic [c_CW-1:0]        w_rx_idx;

   // ss_sel can only exceed NUM_SS-1 when NUM_SS is not a power of two
   generate
      if ((1 << c_SSW) > NUM_SS) begin : g_ss_chk
         assign w_ss_bad = ({1'b0, ss_sel} >= (c_SSW + 1)'(NUM_SS));
      end else begin : g_ss_full
         assign w_ss_bad = 1'b0;
      end
   endgenerate

   assign w_len_bad = (n_clks == '0) || (n_clks > c_MAXLEN);
   assign w_cmd_bad = w_len_bad || w_ss_bad;

   // MSB-first words are left-aligned so the outgoing bit is always the top bit
   assign w_shamt      = c_MAXLEN - n_clks;
   assign w_tx_aligned = lsb_first ? tx_data : (tx_data << w_shamt);

   // Receive source and destination bit position for the bit currently on the wire
   assign w_rx_bit = loop_q ? mosi_q : MISO;
   assign w_rx_idx = lsb_q ? (n_q - cnt_q) : (cnt_q - c_ONE);

   // Decode the requested slave into an active-low one-hot select (none in loopback)
   always_comb begin
      w_ss_n_sel = '1;
      if (!loop_en) begin
         for (int j = 0; j < NUM_SS; j++) begin
            if (c_SSW'(j) == ss_sel) begin
               w_ss_n_sel[j] = 1'b0;
            end
         end
      end
   end

   // Next-state logic: command accept/reject, bit shifting, completion and gap
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      lsb_d      = lsb_q;
      loop_d     = loop_q;
      tx_sh_d    = tx_sh_q;
      mosi_d     = mosi_q;
      ss_n_d     = ss_n_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      cmd_err_d  = 1'b0;
      gap_d      = gap_q;

      case (state_q)
         ST_IDLE: begin
            if (start_cmd && rdy_q) begin
               if (w_cmd_bad) begin
                  cmd_err_d = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
                  n_d     = n_clks;
                  cnt_d   = n_clks;
                  lsb_d   = lsb_first;
                  loop_d  = loop_en;
                  ss_n_d  = w_ss_n_sel;
                  tx_sh_d = w_tx_aligned;
                  mosi_d  = lsb_first ? w_tx_aligned[0] : w_tx_aligned[SPI_MAXLEN-1];
               end
            end
         end

         ST_SHIFT: begin
            if (cnt_q == c_ONE) begin
               // Last bit period ends here: release the slave and publish data
               ss_n_d     = '1;
               mosi_d     = 1'b0;
               cnt_d      = '0;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
               gap_d      = c_GAP_LOAD;
               state_d    = (GAP_CLKS == 0) ? ST_IDLE : ST_DONE;
            end else begin
               cnt_d   = cnt_q - c_ONE;
               tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
               mosi_d  = lsb_q ? tx_sh_d[0] : tx_sh_d[SPI_MAXLEN-1];
            end
         end

         ST_DONE, ST_GAP: begin
            if (gap_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d   = gap_q - 4'd1;
               state_d = ST_GAP;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rdy_d = (state_d == ST_IDLE);
   end

   // Receive assembly: write the sampled bit into its final position; clear when not shifting
   always_comb begin
      rx_sh_d = '0;
      if (state_q == ST_SHIFT) begin
         rx_sh_d = rx_sh_q;
         for (int j = 0; j < SPI_MAXLEN; j++) begin
            if (c_CW'(j) == w_rx_idx) begin
               rx_sh_d[j] = w_rx_bit;
            end
         end
      end
   end

   // Posedge registers: FSM, captured command, transmit path and result outputs
   always_ff @(posedge SCLK or negedge sresetn) begin
      if (!sresetn) begin
         state_q    <= ST_IDLE;
         rdy_q      <= 1'b1;
         cnt_q      <= '0;
         n_q        <= '0;
         lsb_q      <= 1'b0;
         loop_q     <= 1'b0;
         tx_sh_q    <= '0;
         mosi_q     <= 1'b0;
         ss_n_q     <= '1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
         gap_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         lsb_q      <= lsb_d;
         loop_q     <= loop_d;
         tx_sh_q    <= tx_sh_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cmd_err_q  <= cmd_err_d;
         gap_q      <= gap_d;
      end
   end

   // Negedge register: receive shift register samples mid-bit
   always_ff @(negedge SCLK or negedge sresetn) begin
      if (!sresetn) begin
         rx_sh_q <= '0;
      end else begin
         rx_sh_q <= rx_sh_d;
      end
   end

   assign spi_drv_rdy = rdy_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign cmd_err     = cmd_err_q;
   assign MOSI        = mosi_q;
   assign SS_N        = ss_n_q;

endmodule
`default_nettype wire
